// File: rtl/alu_pkg.sv
// Shared definitions for the arithmetic path: FSM state encoding and operation codes.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_unit_bit_adder.sv
// One-bit full-adder cell shared by the bit-serial arithmetic path.
module BitAdder (
    input  logic OPA,
    input  logic OPB,
    input  logic carryIn,
    output logic result,
    output logic carryOut
);

    logic half_sum;

    assign half_sum = OPA ^ OPB;
    assign result   = half_sum ^ carryIn;
    assign carryOut = (OPA & OPB) | (carryIn & half_sum);

endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial add/subtract: one full adder walks the operands LSB first, one bit per clock,
// and publishes result plus carry/overflow/zero flags with a one-cycle done pulse.
module serial_add_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t state_reg;
    state_t state_next;

    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic [WIDTH-1:0] res_sr_reg;
    logic             c_reg;
    logic [CW-1:0]    cnt_reg;
    logic             cin_msb_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_reg;
    logic             zero_reg;

    logic [WIDTH-1:0] b_load;
    logic [WIDTH-1:0] res_next;
    logic             sum_bit;
    logic             cout_bit;
    logic             last_bit;
    logic             accept;

    // Subtract is A + ~B + 1: invert B at load time, the +1 comes from the carry flop.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_b_invert
            assign b_load[gi] = opb[gi] ^ (op == OP_SUB);
        end
    endgenerate

    BitAdder u_bit_adder (
        .OPA      (a_sr_reg[0]),
        .OPB      (b_sr_reg[0]),
        .carryIn  (c_reg),
        .result   (sum_bit),
        .carryOut (cout_bit)
    );

    assign res_next = {sum_bit, res_sr_reg[WIDTH-1:1]};
    assign last_bit = (cnt_reg == CNT_LAST);
    assign accept   = (state_reg == IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr_reg    <= '0;
            b_sr_reg    <= '0;
            res_sr_reg  <= '0;
            c_reg       <= 1'b0;
            cnt_reg     <= '0;
            cin_msb_reg <= 1'b0;
            result_reg  <= '0;
            carry_reg   <= 1'b0;
            zero_reg    <= 1'b0;
        end else if (accept) begin
            a_sr_reg <= opa;
            b_sr_reg <= b_load;
            c_reg    <= op;
            cnt_reg  <= '0;
        end else if (state_reg == RUN) begin
            a_sr_reg   <= {1'b0, a_sr_reg[WIDTH-1:1]};
            b_sr_reg   <= {1'b0, b_sr_reg[WIDTH-1:1]};
            res_sr_reg <= res_next;
            c_reg      <= cout_bit;
            // Hold the counter on the last bit so it never wraps within an operation.
            if (!last_bit) begin
                cnt_reg <= cnt_reg + CW'(1);
            end else begin
                cin_msb_reg <= c_reg;
                result_reg  <= res_next;
                carry_reg   <= cout_bit;
                zero_reg    <= (res_next == '0);
            end
        end
    end

    assign busy     = (state_reg == RUN);
    assign done     = (state_reg == DONE);
    assign result   = result_reg;
    assign carry    = carry_reg;
    assign overflow = cin_msb_reg ^ carry_reg;
    assign zero     = zero_reg;

endmodule

// File: tb/tb_serial_add_unit.sv
// Directed bench for serial_add_unit at WIDTH=8: handshake timing, flags, ignored start, mid-run reset.
module tb_serial_add_unit;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    int busy_cyc;
    int extra_done;

    serial_add_unit #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation; optionally pulse a junk start after inj_at cycles of RUN.
    task automatic run_op(input logic o, input logic [7:0] a, input logic [7:0] b, input int inj_at);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        opa      = ~a;
        opb      = ~b;
        lat      = 0;
        busy_cyc = 0;
        while (!done && lat < 30) begin
            if (busy) busy_cyc++;
            if (lat == inj_at) begin
                start = 1'b1;
                op    = ~o;
                opa   = 8'hFF;
                opb   = 8'h01;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        $display("op=%0d a=%02h b=%02h -> result=%02h c=%0d v=%0d z=%0d latency=%0d busy=%0d",
                 o, a, b, result, carry, overflow, zero, lat, busy_cyc);
    endtask

    task automatic expect_op(input string tag, input logic [7:0] r, input logic c,
                             input logic v, input logic z);
        check({tag, "_latency"}, lat, 8);
        check({tag, "_busy_cycles"}, busy_cyc, 8);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_result"}, result, r);
        check({tag, "_carry"}, carry, c);
        check({tag, "_overflow"}, overflow, v);
        check({tag, "_zero"}, zero, z);
        extra_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        check({tag, "_done_one_pulse"}, extra_done, 0);
        check({tag, "_result_held"}, result, r);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        opa   = '0;
        opb   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_flags", {carry, overflow, zero}, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(1'b0, 8'h05, 8'h03, -1);
        expect_op("add_05_03", 8'h08, 1'b0, 1'b0, 1'b0);
        run_op(1'b0, 8'hFF, 8'h01, -1);
        expect_op("add_FF_01", 8'h00, 1'b1, 1'b0, 1'b1);
        run_op(1'b1, 8'h7F, 8'hFF, -1);
        expect_op("sub_7F_FF", 8'h80, 1'b0, 1'b1, 1'b0);
        run_op(1'b1, 8'h10, 8'h10, -1);
        expect_op("sub_10_10", 8'h00, 1'b1, 1'b0, 1'b1);
        run_op(1'b0, 8'h40, 8'h40, -1);
        expect_op("add_40_40", 8'h80, 1'b0, 1'b1, 1'b0);
        run_op(1'b1, 8'h03, 8'h05, -1);
        expect_op("sub_03_05", 8'hFE, 1'b0, 1'b0, 1'b0);
        run_op(1'b0, 8'h12, 8'h34, 3);
        expect_op("start_in_run", 8'h46, 1'b0, 1'b0, 1'b0);

        // Abort an operation four cycles into RUN with an asynchronous reset.
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        opa   = 8'h55;
        opb   = 8'h22;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_flags", {carry, overflow, zero}, 0);
        @(negedge clk);
        rst = 1'b0;
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra_done++;
        end
        check("abort_no_done", extra_done, 0);
        $display("reset abort: busy=%0d done=%0d result=%02h", busy, done, result);

        run_op(1'b0, 8'h01, 8'h01, -1);
        expect_op("add_after_reset", 8'h02, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
